// File: rtl/ddr3_ctrl_pkg.sv
// Shared types and helpers for the DDR3 closed-page command controller.
package ddr3_ctrl_pkg;

  // {cke, cs_n, ras_n, cas_n, we_n}
  typedef enum logic [4:0] {
    CMD_RESET = 5'b0_1111,
    CMD_NOP   = 5'b1_0111,
    CMD_ACT   = 5'b1_0011,
    CMD_RD    = 5'b1_0101,
    CMD_WR    = 5'b1_0100,
    CMD_PRE   = 5'b1_0010,
    CMD_REF   = 5'b1_0001,
    CMD_MRS   = 5'b1_0000
  } cmd_e;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_PREA,
    ST_RP_WAIT,
    ST_MRS0,
    ST_MRD_WAIT,
    ST_IDLE,
    ST_ACT,
    ST_RCD_WAIT,
    ST_RDWR,
    ST_RC_WAIT,
    ST_REF,
    ST_RFC_WAIT
  } state_e;

  localparam int unsigned A10 = 10;

  function automatic logic [4:0] cmd_bits(input cmd_e c);
    return c;
  endfunction

  function automatic logic [63:0] addr_field(input logic [63:0] a, input int unsigned lsb,
                                             input int unsigned w);
    return (a >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic int unsigned tmax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_strobe_delay.sv
// Fixed-latency single-bit delay line used to time the data-strobe pulses.
module ddr3_strobe_delay #(
  parameter int unsigned DEPTH = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ddr3_cmd_ctrl.sv
// Closed-page DDR3 command initiator: power-up, ACT -> RD/WR with auto-precharge,
// periodic refresh, and CL/CWL-timed data strobes.
module ddr3_cmd_ctrl
  import ddr3_ctrl_pkg::*;
#(
  parameter int unsigned    ROW_W   = 14,
  parameter int unsigned    COL_W   = 10,
  parameter int unsigned    BA_W    = 3,
  parameter int unsigned    T_INIT  = 500,
  parameter int unsigned    T_MRD   = 4,
  parameter int unsigned    T_RP    = 6,
  parameter int unsigned    T_RCD   = 6,
  parameter int unsigned    T_RC    = 20,
  parameter int unsigned    T_RFC   = 44,
  parameter int unsigned    T_REFI  = 3120,
  parameter int unsigned    CL      = 6,
  parameter int unsigned    CWL     = 5,
  parameter logic [ROW_W-1:0] MR0_VAL = 14'h0520
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [BA_W+ROW_W+COL_W-1:0] req_addr,
  output logic                        init_done,
  output logic                        cke,
  output logic                        cs_n,
  output logic                        ras_n,
  output logic                        cas_n,
  output logic                        we_n,
  output logic [BA_W-1:0]             ba,
  output logic [ROW_W-1:0]            addr,
  output logic                        wr_data_en,
  output logic                        rd_data_valid
);

  localparam int unsigned T_MAX  = tmax(tmax(tmax(T_INIT, T_RFC), tmax(T_RC, T_RCD)), tmax(T_RP, T_MRD));
  localparam int unsigned CNT_W  = $clog2(T_MAX) + 1;
  localparam int unsigned REFI_W = $clog2(T_REFI + 1);

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                cnt_done;
  logic [REFI_W-1:0]   refi_cnt;
  logic                refi_expire, refresh_pending;
  logic                handshake;
  logic                lat_write;
  logic [BA_W-1:0]     lat_bank, req_bank;
  logic [COL_W-1:0]    lat_col, req_col;
  logic [ROW_W-1:0]    req_row;
  cmd_e                cmd_nxt;
  logic [BA_W-1:0]     ba_nxt;
  logic [ROW_W-1:0]    addr_nxt;

  assign req_bank    = BA_W'(addr_field(64'(req_addr), ROW_W + COL_W, BA_W));
  assign req_row     = ROW_W'(addr_field(64'(req_addr), COL_W, ROW_W));
  assign req_col     = COL_W'(addr_field(64'(req_addr), 0, COL_W));
  assign cnt_done    = (cnt <= CNT_W'(1));
  assign refi_expire = init_done && (refi_cnt == REFI_W'(T_REFI - 1));
  assign req_ready   = (state == ST_IDLE) && !refresh_pending && !refi_expire;
  assign handshake   = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                         <= ST_INIT_WAIT;
      cnt                           <= CNT_W'(T_INIT);
      {cke, cs_n, ras_n, cas_n, we_n} <= cmd_bits(CMD_RESET);
      ba                            <= '0;
      addr                          <= '0;
    end else begin
      state                         <= state_nxt;
      cnt                           <= cnt_nxt;
      {cke, cs_n, ras_n, cas_n, we_n} <= cmd_bits(cmd_nxt);
      ba                            <= ba_nxt;
      addr                          <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT_WAIT: if (cnt_done) state_nxt = ST_PREA;
      ST_PREA:      state_nxt = ST_RP_WAIT;
      ST_RP_WAIT:   if (cnt_done) state_nxt = ST_MRS0;
      ST_MRS0:      state_nxt = ST_MRD_WAIT;
      ST_MRD_WAIT:  if (cnt_done) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (refresh_pending || refi_expire) state_nxt = ST_REF;
        else if (handshake)                 state_nxt = ST_ACT;
      end
      ST_ACT:       state_nxt = ST_RCD_WAIT;
      ST_RCD_WAIT:  if (cnt_done) state_nxt = ST_RDWR;
      ST_RDWR:      state_nxt = ST_RC_WAIT;
      ST_RC_WAIT:   if (cnt_done) state_nxt = ST_IDLE;
      ST_REF:       state_nxt = ST_RFC_WAIT;
      ST_RFC_WAIT:  if (cnt_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_INIT_WAIT;
    endcase
  end

  // Counter is loaded as the command is issued and runs through the following wait
  // state, so each delay is measured from the command cycle itself.
  always_comb begin
    cnt_nxt = (cnt != '0) ? cnt - CNT_W'(1) : '0;
    if (state_nxt != state) begin
      unique case (state_nxt)
        ST_PREA: cnt_nxt = CNT_W'(T_RP);
        ST_MRS0: cnt_nxt = CNT_W'(T_MRD);
        ST_ACT:  cnt_nxt = CNT_W'(T_RCD);
        ST_RDWR: cnt_nxt = CNT_W'(T_RC - T_RCD);
        ST_REF:  cnt_nxt = CNT_W'(T_RFC);
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_nxt  = CMD_NOP;
    ba_nxt   = '0;
    addr_nxt = '0;
    unique case (state_nxt)
      ST_PREA: begin
        cmd_nxt       = CMD_PRE;
        addr_nxt[A10] = 1'b1;
      end
      ST_MRS0: begin
        cmd_nxt  = CMD_MRS;
        addr_nxt = MR0_VAL;
      end
      ST_ACT: begin
        cmd_nxt  = CMD_ACT;
        ba_nxt   = req_bank;
        addr_nxt = req_row;
      end
      ST_RDWR: begin
        cmd_nxt       = lat_write ? CMD_WR : CMD_RD;
        ba_nxt        = lat_bank;
        addr_nxt      = ROW_W'(lat_col);
        addr_nxt[A10] = 1'b1;
      end
      ST_REF:  cmd_nxt = CMD_REF;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_done       <= 1'b0;
      refi_cnt        <= '0;
      refresh_pending <= 1'b0;
      lat_write       <= 1'b0;
      lat_bank        <= '0;
      lat_col         <= '0;
    end else begin
      if (state == ST_MRD_WAIT && state_nxt == ST_IDLE) init_done <= 1'b1;
      if (init_done)
        refi_cnt <= (refi_cnt == REFI_W'(T_REFI - 1)) ? '0 : refi_cnt + REFI_W'(1);
      // A single flag: an expiry while one refresh is already owed is absorbed.
      if (state_nxt == ST_REF) refresh_pending <= 1'b0;
      else if (refi_expire)    refresh_pending <= 1'b1;
      if (handshake) begin
        lat_write <= req_write;
        lat_bank  <= req_bank;
        lat_col   <= req_col;
      end
    end
  end

  ddr3_strobe_delay #(.DEPTH(CL)) u_rd_delay (
    .clk   (clk),
    .reset (reset),
    .din   (state == ST_RDWR && !lat_write),
    .dout  (rd_data_valid)
  );

  ddr3_strobe_delay #(.DEPTH(CWL)) u_wr_delay (
    .clk   (clk),
    .reset (reset),
    .din   (state == ST_RDWR && lat_write),
    .dout  (wr_data_en)
  );

endmodule

// File: tb/tb_ddr3_cmd_ctrl.sv
// Directed bench for ddr3_cmd_ctrl: init, read, write, refresh arbitration,
// async reset recovery, and refresh-expiry merging on a fast-refresh instance.
module tb_ddr3_cmd_ctrl;

  localparam logic [3:0] B_NOP = 4'b0111, B_ACT = 4'b0011, B_RD = 4'b0101, B_WR = 4'b0100,
                         B_PRE = 4'b0010, B_REF = 4'b0001, B_MRS = 4'b0000;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write, init_done;
  logic [26:0] req_addr;
  logic        cke, cs_n, ras_n, cas_n, we_n, wr_data_en, rd_data_valid;
  logic [2:0]  ba;
  logic [13:0] addr;

  logic        r_req_valid, r_req_ready, r_req_write, r_init_done;
  logic [26:0] r_req_addr;
  logic        r_cke, r_cs_n, r_ras_n, r_cas_n, r_we_n, r_wr_data_en, r_rd_data_valid;
  logic [2:0]  r_ba;
  logic [13:0] r_addr;

  int unsigned total, bad, edge_n, rdv_seen;
  int unsigned ref_edges[$];

  ddr3_cmd_ctrl u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .init_done(init_done), .cke(cke),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
    .wr_data_en(wr_data_en), .rd_data_valid(rd_data_valid)
  );

  ddr3_cmd_ctrl #(.T_INIT(20), .T_REFI(20)) u_ref (
    .clk(clk), .reset(reset), .req_valid(r_req_valid), .req_ready(r_req_ready),
    .req_write(r_req_write), .req_addr(r_req_addr), .init_done(r_init_done), .cke(r_cke),
    .cs_n(r_cs_n), .ras_n(r_ras_n), .cas_n(r_cas_n), .we_n(r_we_n), .ba(r_ba), .addr(r_addr),
    .wr_data_en(r_wr_data_en), .rd_data_valid(r_rd_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && r_cke && {r_cs_n, r_ras_n, r_cas_n, r_we_n} == B_REF) ref_edges.push_back(edge_n);

  initial begin
    #1000000;
    $display("FAIL timeout edge=%0d", edge_n);
    $fatal(1);
  end

  function automatic logic [3:0] bus();
    return {cs_n, ras_n, cas_n, we_n};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (rd_data_valid) rdv_seen++;
  endtask

  task automatic wait_cmd(input logic [3:0] c, input int unsigned limit, output int unsigned at);
    at = 0;
    for (int unsigned i = 0; i < limit; i++) begin
      tick();
      if (cke && bus() == c) begin
        at = edge_n;
        return;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cke"}, cke, 0);
    chk({tag, "_bus"}, bus(), 4'b1111);
    chk({tag, "_ba"}, ba, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_init"}, init_done, 0);
    chk({tag, "_rdv"}, rd_data_valid, 0);
    chk({tag, "_wde"}, wr_data_en, 0);
  endtask

  task automatic hit_reset(input string tag);
    #2 reset = 1'b1;
    #1 chk_reset_vals(tag);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_init(input string tag);
    int unsigned at;
    @(negedge clk);
    reset  = 1'b0;
    edge_n = 0;
    tick();
    chk({tag, "_cke1"}, cke, 1);
    chk({tag, "_nop1"}, bus(), B_NOP);
    wait_cmd(B_PRE, 600, at);
    chk({tag, "_pre_at"}, at, 500);
    chk({tag, "_pre_a10"}, addr[10], 1);
    wait_cmd(B_MRS, 20, at);
    chk({tag, "_mrs_at"}, at, 506);
    chk({tag, "_mrs_addr"}, addr, 14'h0520);
    chk({tag, "_mrs_ba"}, ba, 0);
    at = 0;
    for (int unsigned i = 0; i < 20 && at == 0; i++) begin
      tick();
      if (init_done) at = edge_n;
    end
    chk({tag, "_init_at"}, at, 510);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  initial begin
    int unsigned a, k, ref_at, act_after, refs;
    total = 0; bad = 0; edge_n = 0; rdv_seen = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    r_req_valid = 1'b0; r_req_write = 1'b0; r_req_addr = '0;

    // power-up
    repeat (10) @(posedge clk);
    #1 chk_reset_vals("t1_rst");
    do_init("t1");

    // fast-refresh instance: expiries every 20, REF every 45 (one expiry per REF dropped)
    chk("t6_nref", ref_edges.size(), 11);
    if (ref_edges.size() >= 5) begin
      chk("t6_ref0", ref_edges[0], 50);
      chk("t6_ref1", ref_edges[1], 95);
      chk("t6_ref2", ref_edges[2], 140);
      chk("t6_ref4", ref_edges[4], 230);
    end

    // read bank 3 row 1A2B col 040
    req_write = 1'b0; req_addr = {3'd3, 14'h1A2B, 10'h040}; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t2_act", bus(), B_ACT);
    chk("t2_act_ba", ba, 3);
    chk("t2_act_row", addr, 14'h1A2B);
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      chk("t2_bus", bus(), (i == 6) ? B_RD : B_NOP);
      if (i == 6) begin
        chk("t2_rd_addr", addr, 14'h0440);
        chk("t2_rd_ba", ba, 3);
      end
      chk("t2_rdv", rd_data_valid, (i == 12));
      chk("t2_ready", req_ready, (i == 20));
    end

    // write bank 7 row 0 col 3FF
    req_write = 1'b1; req_addr = {3'd7, 14'h0000, 10'h3FF}; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    a = edge_n;
    chk("t3_act_at", a, 532);
    chk("t3_act", bus(), B_ACT);
    chk("t3_act_ba", ba, 7);
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      chk("t3_bus", bus(), (i == 6) ? B_WR : B_NOP);
      if (i == 6) begin
        chk("t3_wr_addr", addr, 14'h07FF);
        chk("t3_wr_ba", ba, 7);
      end
      chk("t3_wde", wr_data_en, (i == 11));
      chk("t3_rdv", rd_data_valid, 0);
    end

    // continuous reads across the first refresh expiry (sampled at edge 3630)
    k = 0; ref_at = 0; act_after = 0; refs = 0;
    req_write = 1'b0; req_addr = {3'd1, 14'(k), 10'h000}; req_valid = 1'b1;
    while (edge_n < 3700) begin
      tick();
      if (bus() == B_ACT) begin
        chk("t4_row", addr, k);
        if (ref_at != 0 && act_after == 0) act_after = edge_n;
        k++;
        req_addr = {3'd1, 14'(k), 10'h000};
      end
      if (bus() == B_REF) begin
        refs++;
        if (ref_at == 0) ref_at = edge_n;
      end
    end
    req_valid = 1'b0;
    chk("t4_ref_at", ref_at, 3640);
    chk("t4_act_after", act_after, 3685);
    chk("t4_nref", refs, 1);
    chk("t4_nreq", k, 148);

    // async reset during RCD_WAIT
    for (int unsigned i = 0; i < 50 && !req_ready; i++) tick();
    chk("t5_ready", req_ready, 1);
    req_write = 1'b0; req_addr = {3'd2, 14'h0155, 10'h011}; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t5_act", bus(), B_ACT);
    tick();
    hit_reset("t5a");
    do_init("t5a");

    // async reset with a read strobe in flight
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t5b_act", bus(), B_ACT);
    repeat (6) tick();
    chk("t5b_rd", bus(), B_RD);
    repeat (3) tick();
    hit_reset("t5b");
    rdv_seen = 0;
    do_init("t5b");
    chk("t5b_stale_rdv", rdv_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
